// File: rtl/mux_nx1_arb_fifo_seq.sv
// N-to-1 sequential mux: command or round-robin channel selection feeding a
// small output FIFO, with valid/ready backpressure on both sides.
module mux_nx1_arb_fifo_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_IN        = 4,
  parameter int COMMAND_WIDTH = 2,
  parameter int FIFO_DEPTH    = 2,
  parameter int CNT_WIDTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            i_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_data_bus,
  output logic [NUM_IN-1:0]            o_in_ready,
  input  logic                         i_en,
  input  logic                         i_mode,
  input  logic [COMMAND_WIDTH-1:0]     i_cmd,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data_bus,
  output logic [COMMAND_WIDTH-1:0]     o_grant_idx,
  input  logic                         i_ready,
  output logic [CNT_WIDTH-1:0]         o_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0]    data_mem [FIFO_DEPTH];
  logic [COMMAND_WIDTH-1:0] idx_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_WIDTH-1:0]     count;
  logic [COMMAND_WIDTH-1:0] rr_ptr;
  logic [COMMAND_WIDTH-1:0] sel;
  logic [COMMAND_WIDTH-1:0] cand;
  logic                     sel_found;
  logic                     sel_valid;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     space;
  logic                     push;
  logic                     pop;
  int                       scan_idx;

  // Round-robin scans upward from the channel after the last winner.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    cand      = '0;
    scan_idx  = 0;
    if (!i_mode) begin
      sel       = i_cmd;
      sel_found = (32'(i_cmd) < NUM_IN);
    end else begin
      for (int off = 1; off <= NUM_IN; off++) begin
        scan_idx = (32'(rr_ptr) + off) % NUM_IN;
        cand     = COMMAND_WIDTH'(scan_idx);
        if (!sel_found && i_valid[cand]) begin
          sel_found = 1'b1;
          sel       = cand;
        end
      end
    end
  end

  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready;
  assign space   = (count < CNT_WIDTH'(FIFO_DEPTH)) || pop;

  always_comb begin
    sel_data   = '0;
    sel_valid  = 1'b0;
    o_in_ready = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_found && (COMMAND_WIDTH'(k) == sel)) begin
        sel_data      = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
        sel_valid     = i_valid[k];
        o_in_ready[k] = i_en && space;
      end
    end
  end

  assign push = i_en && space && sel_found && sel_valid;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= COMMAND_WIDTH'(NUM_IN - 1);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_WIDTH'(1);
      else if (pop && !push)
        count <= count - CNT_WIDTH'(1);
      if (push && i_mode) rr_ptr <= sel;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (!rst_n && push) begin
      data_mem[wr_ptr] <= sel_data;
      idx_mem[wr_ptr]  <= sel;
    end
  end

  assign o_data_bus  = o_valid ? data_mem[rd_ptr] : '0;
  assign o_grant_idx = o_valid ? idx_mem[rd_ptr]  : '0;
  assign o_count     = count;

endmodule

// File: tb/tb_mux_nx1_arb_fifo_seq.sv
// Scoreboard bench: stimulus enqueues expected beats, a monitor pops and
// compares them whenever the DUT head is consumed.
module tb_mux_nx1_arb_fifo_seq;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_valid;
  logic [127:0] i_data_bus;
  logic [3:0]  o_in_ready;
  logic        i_en;
  logic        i_mode;
  logic [1:0]  i_cmd;
  logic        o_valid;
  logic [31:0] o_data_bus;
  logic [1:0]  o_grant_idx;
  logic        i_ready;
  logic [1:0]  o_count;

  logic [2:0]  dut3_in_ready;
  logic        dut3_valid;
  logic [31:0] dut3_data;
  logic [1:0]  dut3_grant;
  logic [1:0]  dut3_count;

  int          vectors;
  int          miscompares;
  logic [15:0] tag;
  logic [33:0] exp_q [$];

  mux_nx1_arb_fifo_seq dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .o_in_ready(o_in_ready), .i_en(i_en), .i_mode(i_mode), .i_cmd(i_cmd),
    .o_valid(o_valid), .o_data_bus(o_data_bus), .o_grant_idx(o_grant_idx),
    .i_ready(i_ready), .o_count(o_count)
  );

  mux_nx1_arb_fifo_seq #(.NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid[2:0]), .i_data_bus(i_data_bus[95:0]),
    .o_in_ready(dut3_in_ready), .i_en(i_en), .i_mode(i_mode), .i_cmd(i_cmd),
    .o_valid(dut3_valid), .o_data_bus(dut3_data), .o_grant_idx(dut3_grant),
    .i_ready(i_ready), .o_count(dut3_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check the hand-computed accept vector and
  // enqueue the beat that accept implies.
  task automatic applyStimulus(input logic [3:0] valid, input logic mode,
                               input logic [1:0] cmd, input logic en,
                               input logic ready, input logic [3:0] exp_ready);
    @(posedge clk); #1;
    i_valid = valid;
    i_mode  = mode;
    i_cmd   = cmd;
    i_en    = en;
    i_ready = ready;
    for (int k = 0; k < 4; k++) i_data_bus[k*32 +: 32] = {tag, 16'(k)};
    @(negedge clk);
    checkOutput("in_ready", 32'(o_in_ready), 32'(exp_ready));
    for (int k = 0; k < 4; k++)
      if (exp_ready[k] && valid[k]) exp_q.push_back({2'(k), tag, 16'(k)});
    tag = tag + 16'd1;
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst_n   = 1'b1;
    i_valid = '0;
    i_en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("reset_count", 32'(o_count), 32'd0);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
  endtask

  // Monitor: a pop happens at the coming edge when o_valid && i_ready.
  always @(negedge clk) begin
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_beat: got data %h grant %0d, expected none", o_data_bus, o_grant_idx);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        checkOutput("beat_data", o_data_bus, e[31:0]);
        checkOutput("beat_grant", 32'(o_grant_idx), 32'(e[33:32]));
      end
    end else if (!o_valid && !rst_n) begin
      checkOutput("empty_data", o_data_bus, 32'd0);
      checkOutput("empty_grant", 32'(o_grant_idx), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    tag         = 16'hAAAA;
    rst_n       = 1'b1;
    i_valid     = '0;
    i_data_bus  = '0;
    i_en        = 1'b0;
    i_mode      = 1'b0;
    i_cmd       = '0;
    i_ready     = 1'b1;

    applyReset();

    // Command select of channel 2, one-cycle latency to the head.
    applyStimulus(4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0100);
    applyStimulus(4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0100);
    checkOutput("count_one", 32'(o_count), 32'd1);
    checkOutput("valid_one", 32'(o_valid), 32'd1);
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000);
    checkOutput("count_drained", 32'(o_count), 32'd0);

    // Ready is independent of valid in command mode.
    applyStimulus(4'b0001, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0010);
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000);
    checkOutput("no_push_valid", 32'(o_valid), 32'd0);
    checkOutput("no_push_count", 32'(o_count), 32'd0);

    // Round-robin over all four channels.
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0001);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0010);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0100);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 4'b1000);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0001);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    checkOutput("rr_tail_count", 32'(o_count), 32'd1);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    checkOutput("rr_empty_count", 32'(o_count), 32'd0);

    // Out-of-range command on a 3-input build gives no selection.
    applyReset();
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b1, 1'b1, 4'b1000);
    checkOutput("n3_cmd3_ready", 32'(dut3_in_ready), 32'd0);
    applyStimulus(4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0100);
    checkOutput("n3_cmd2_ready", 32'(dut3_in_ready), 32'b100);

    // Backpressure fill, then push into a full FIFO alongside a pop.
    applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0010);
    applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000);
    checkOutput("full_count", 32'(o_count), 32'd2);
    applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0001);
    applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0010);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    checkOutput("pushpop_count", 32'(o_count), 32'd2);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    checkOutput("drain1_count", 32'(o_count), 32'd1);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    checkOutput("drain0_count", 32'(o_count), 32'd0);

    // Disabled accept while draining.
    applyStimulus(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b0001, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000);
    checkOutput("en0_count2", 32'(o_count), 32'd2);
    applyStimulus(4'b0001, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000);
    checkOutput("en0_count1", 32'(o_count), 32'd1);
    applyStimulus(4'b0001, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000);
    checkOutput("en0_count0", 32'(o_count), 32'd0);

    // Reset colliding with push and pop on a full FIFO.
    applyStimulus(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    checkOutput("collide_ready", 32'(o_in_ready), 32'b0001);
    checkOutput("collide_count", 32'(o_count), 32'd2);
    @(posedge clk); #1;
    rst_n   = 1'b0;
    i_valid = '0;
    i_en    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("post_rst_count", 32'(o_count), 32'd0);
    checkOutput("post_rst_valid", 32'(o_valid), 32'd0);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0001);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0000);

    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_nx1_arb_fifo_seq.md
Name: mux_nx1_arb_fifo_seq

Overview:
- Parametrised N-to-1 sequential mux that generalises the 2x1 selector.
- Selects one of NUM_IN input channels, either by explicit command or by round-robin arbitration among valid inputs.
- Accepted beats are buffered in a FIFO_DEPTH-entry output FIFO with valid/ready backpressure on both sides.
- Sits at NoC router output ports and reduction-tree merge points where upstream channels must be stalled rather than dropped.

Parameters:
- DATA_WIDTH, 32, payload width per channel.
- NUM_IN, 4, number of input channels; must be at least 2.
- COMMAND_WIDTH, 2, width of i_cmd and o_grant_idx; must equal clog2(NUM_IN).
- FIFO_DEPTH, 2, output FIFO entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 2, width of o_count; must equal clog2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active-high: 1 resets the block on the next rising clk edge.
- i_valid  input  NUM_IN  per-channel valid; bit k belongs to channel k.
- i_data_bus  input  NUM_IN*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_in_ready  output  NUM_IN  per-channel accept; at most one bit is high in any cycle.
- i_en  input  1  accept enable; when low, nothing is accepted.
- i_mode  input  1  0 = command select, 1 = round-robin.
- i_cmd  input  COMMAND_WIDTH  selected channel index in mode 0.
- o_valid  output  1  FIFO head valid.
- o_data_bus  output  DATA_WIDTH  FIFO head data.
- o_grant_idx  output  COMMAND_WIDTH  source channel of the FIFO head.
- i_ready  input  1  downstream ready.
- o_count  output  CNT_WIDTH  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset: FIFO emptied, rd/wr pointers 0, o_count=0, o_valid=0, o_data_bus=0, o_grant_idx=0, rr_ptr=NUM_IN-1 (so channel 0 has first priority). Reset overrides any concurrent push or pop; a reset mid-stream discards all buffered beats.
- Pop: occurs when o_valid && i_ready.
- space: equals (o_count<FIFO_DEPTH) || pop. A push into a full FIFO is therefore allowed in the same cycle as a pop.
- Selection, combinational and evaluated each cycle:
  - Mode 0: sel=i_cmd. If i_cmd>=NUM_IN, there is no selection.
  - Mode 1: sel is the first k with i_valid[k]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN. If no input is valid, there is no selection.
- Accept/push: o_in_ready[sel]=i_en && space && (selection exists). Push occurs when o_in_ready[sel] && i_valid[sel].
  - o_in_ready must not depend on i_valid in mode 0. In mode 1 it depends on i_valid only through sel.
- Round-robin pointer: rr_ptr<=sel only on a push in mode 1. It is unchanged in mode 0 and on cycles with no push.
- Latency: a beat pushed into an empty FIFO appears on o_valid/o_data_bus/o_grant_idx on the next cycle. There is no combinational input-to-output path.
- Ordering: output order is strictly push order.
- Outputs while empty: o_valid=0 and o_data_bus=0 (dummy zeros); o_grant_idx holds 0.
- Simultaneous push and pop: o_count unchanged, both pointers advance.
- Pointer wrap-around: pointers wrap modulo FIFO_DEPTH; o_count distinguishes full from empty.
- i_en=0: o_in_ready=0; draining continues normally.
- i_mode or i_cmd change: takes effect on the same cycle's selection; buffered beats are unaffected.
- Held data: o_data_bus and o_grant_idx remain stable while o_valid && !i_ready.

Test Plan:
- Mode 0, i_cmd=2, i_valid=4'b0100, ch2=0xAAAA0002, i_ready=1 -> o_in_ready=4'b0100; next cycle o_valid=1, o_data_bus=0xAAAA0002, o_grant_idx=2, o_count=1.
- Mode 1, i_valid=4'b1111 held, i_ready=1, after reset -> grants cycle 0,1,2,3,0; o_grant_idx sequence on o_valid is 0,1,2,3,0.
- Mode 1, i_ready=0, i_valid=4'b0011 -> two pushes (ch0, then ch1), then o_count=2 and o_in_ready=0. Raise i_ready -> ch0 beat then ch1 beat appear in order; with i_valid still high, a push occurs in the same cycle as the first pop.
- Mode 0, i_cmd=1, i_valid=4'b0001 -> o_in_ready=4'b0010, no push, o_valid stays 0, o_data_bus=0. Then NUM_IN=3 build, i_cmd=3 -> o_in_ready=0.
- i_en=0 with two beats buffered and i_ready=1 -> o_in_ready=0, FIFO drains to o_count=0 over 2 cycles.
- rst_n=1 with FIFO full and push and pop both active -> next cycle o_count=0, o_valid=0, o_data_bus=0; first mode-1 grant afterwards is channel 0.
